// File: rtl/score_control.sv
`default_nettype none
// ============================================================================
// score_control : penalty-shootout referee; alternates shoot/keep turns,
//                 keeps both scores, detects early/sudden-death/draw decisions.
// Revision      : 1.0
// ============================================================================
module score_control #(
    parameter int ROUNDS     = 5,
    parameter int MAX_ROUNDS = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       match_start,
    input  logic       shooter_done,
    input  logic       shooter_scored,
    input  logic       keeper_done,
    input  logic       keeper_conceded,
    output logic [3:0] player_score,
    output logic [3:0] cpu_score,
    output logic [3:0] round_num,
    output logic       turn,
    output logic       sudden_death,
    output logic       match_over,
    output logic       player_won,
    output logic       draw
);

    localparam logic [3:0] c_ROUNDS     = 4'(ROUNDS);
    localparam logic [3:0] c_MAX_ROUNDS = 4'(MAX_ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHOOT = 3'd1,
        S_KEEP  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     r_state, w_state_nxt;
    state_t     r_ret,   w_ret_nxt;
    logic [3:0] r_pkicks, w_pkicks_nxt;
    logic [3:0] r_ckicks, w_ckicks_nxt;
    logic [3:0] r_pscore, w_pscore_nxt;
    logic [3:0] r_cscore, w_cscore_nxt;
    logic [3:0] r_round,  w_round_nxt;
    logic       r_turn,   w_turn_nxt;
    logic       r_sd,     w_sd_nxt;
    logic       r_over,   w_over_nxt;
    logic       r_won,    w_won_nxt;
    logic       r_draw,   w_draw_nxt;

    logic [3:0] w_rem_p, w_rem_c;
    logic       w_in_reg, w_reg_decided, w_round_done, w_decided;

    function automatic logic [3:0] f_sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Remaining kicks are only meaningful inside regulation; outside it the
    // wrapped values are masked by w_in_reg.
    assign w_in_reg      = (r_pkicks <= c_ROUNDS) && (r_ckicks <= c_ROUNDS);
    assign w_rem_p       = c_ROUNDS - r_pkicks;
    assign w_rem_c       = c_ROUNDS - r_ckicks;
    assign w_reg_decided = w_in_reg && ((r_pscore > r_cscore + w_rem_c) ||
                                        (r_cscore > r_pscore + w_rem_p));
    assign w_round_done  = (r_pkicks == r_ckicks) && (r_pkicks >= c_ROUNDS);
    assign w_decided     = w_reg_decided ||
                           (w_round_done && ((r_pscore != r_cscore) ||
                                             (r_round == c_MAX_ROUNDS)));

    always_comb begin
        w_state_nxt  = r_state;
        w_ret_nxt    = r_ret;
        w_pkicks_nxt = r_pkicks;
        w_ckicks_nxt = r_ckicks;
        w_pscore_nxt = r_pscore;
        w_cscore_nxt = r_cscore;
        w_round_nxt  = r_round;
        w_turn_nxt   = r_turn;
        w_over_nxt   = r_over;
        w_won_nxt    = r_won;
        w_draw_nxt   = r_draw;

        if (match_start) begin
            w_state_nxt  = S_SHOOT;
            w_ret_nxt    = S_KEEP;
            w_pkicks_nxt = 4'd0;
            w_ckicks_nxt = 4'd0;
            w_pscore_nxt = 4'd0;
            w_cscore_nxt = 4'd0;
            w_round_nxt  = 4'd1;
            w_turn_nxt   = 1'b0;
            w_over_nxt   = 1'b0;
            w_won_nxt    = 1'b0;
            w_draw_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_SHOOT: if (shooter_done) begin
                    w_pkicks_nxt = f_sat_inc(r_pkicks);
                    if (shooter_scored) w_pscore_nxt = f_sat_inc(r_pscore);
                    w_state_nxt  = S_CHECK;
                    w_ret_nxt    = S_KEEP;
                end
                S_KEEP: if (keeper_done) begin
                    w_ckicks_nxt = f_sat_inc(r_ckicks);
                    if (keeper_conceded) w_cscore_nxt = f_sat_inc(r_cscore);
                    w_state_nxt  = S_CHECK;
                    w_ret_nxt    = S_SHOOT;
                end
                S_CHECK: begin
                    if (w_decided) begin
                        w_state_nxt = S_DONE;
                        w_over_nxt  = 1'b1;
                        w_won_nxt   = (r_pscore > r_cscore);
                        w_draw_nxt  = (r_pscore == r_cscore);
                    end else begin
                        w_state_nxt = r_ret;
                        w_turn_nxt  = (r_ret == S_KEEP);
                        if (r_ret == S_SHOOT) w_round_nxt = f_sat_inc(r_round);
                    end
                end
                S_IDLE, S_DONE: ;
                default: w_state_nxt = S_IDLE;
            endcase
        end

        w_sd_nxt = (w_state_nxt != S_IDLE) && (w_round_nxt > c_ROUNDS);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_ret    <= S_KEEP;
            r_pkicks <= 4'd0;
            r_ckicks <= 4'd0;
            r_pscore <= 4'd0;
            r_cscore <= 4'd0;
            r_round  <= 4'd0;
            r_turn   <= 1'b0;
            r_sd     <= 1'b0;
            r_over   <= 1'b0;
            r_won    <= 1'b0;
            r_draw   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ret    <= w_ret_nxt;
            r_pkicks <= w_pkicks_nxt;
            r_ckicks <= w_ckicks_nxt;
            r_pscore <= w_pscore_nxt;
            r_cscore <= w_cscore_nxt;
            r_round  <= w_round_nxt;
            r_turn   <= w_turn_nxt;
            r_sd     <= w_sd_nxt;
            r_over   <= w_over_nxt;
            r_won    <= w_won_nxt;
            r_draw   <= w_draw_nxt;
        end
    end

    assign player_score = r_pscore;
    assign cpu_score    = r_cscore;
    assign round_num    = r_round;
    assign turn         = r_turn;
    assign sudden_death = r_sd;
    assign match_over   = r_over;
    assign player_won   = r_won;
    assign draw         = r_draw;

endmodule
`default_nettype wire

// File: tb/tb_score_control.sv
`default_nettype none
// ============================================================================
// tb_score_control : directed scenario bench for score_control (ROUNDS=5,
//                    MAX_ROUNDS=15). Status word = {ps,cs,round,turn,sd,over,won,draw}.
// Revision         : 1.0
// ============================================================================
module tb_score_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       match_start, shooter_done, shooter_scored, keeper_done, keeper_conceded;
    logic [3:0] player_score, cpu_score, round_num;
    logic       turn, sudden_death, match_over, player_won, draw;
    logic [16:0] st;
    logic [16:0] exp_st;
    int         pass_cnt  = 0;
    int         total_cnt = 0;

    score_control #(.ROUNDS(5), .MAX_ROUNDS(15)) dut (
        .clk             (clk),
        .rst             (rst),
        .match_start     (match_start),
        .shooter_done    (shooter_done),
        .shooter_scored  (shooter_scored),
        .keeper_done     (keeper_done),
        .keeper_conceded (keeper_conceded),
        .player_score    (player_score),
        .cpu_score       (cpu_score),
        .round_num       (round_num),
        .turn            (turn),
        .sudden_death    (sudden_death),
        .match_over      (match_over),
        .player_won      (player_won),
        .draw            (draw)
    );

    always #5 clk = ~clk;

    assign st = {player_score, cpu_score, round_num, turn, sudden_death,
                 match_over, player_won, draw};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        match_start = 1'b1;
        tick();
        match_start = 1'b0;
    endtask

    // One player kick: pulse cycle, then the CHECK cycle.
    task automatic shoot(input logic s);
        shooter_done = 1'b1; shooter_scored = s;
        tick();
        shooter_done = 1'b0; shooter_scored = 1'b0;
        tick();
    endtask

    task automatic keep(input logic c);
        keeper_done = 1'b1; keeper_conceded = c;
        tick();
        keeper_done = 1'b0; keeper_conceded = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #12;
        total_cnt++;
        if (st !== 17'd0) $display("FAIL reset_state: got %h expected %h", st, 17'd0);
        else pass_cnt++;
        @(posedge clk); #1 rst = 1'b1;
        shooter_done = 1'b1; shooter_scored = 1'b1; keeper_done = 1'b1; keeper_conceded = 1'b1;
        tick();
        shooter_done = 1'b0; shooter_scored = 1'b0; keeper_done = 1'b0; keeper_conceded = 1'b0;
        tick();
        total_cnt++;
        if (st !== 17'd0) $display("FAIL idle_ignores_done: got %h expected %h", st, 17'd0);
        else pass_cnt++;
    endtask

    task automatic test_player_sweep();
        start();
        exp_st = {4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (st !== exp_st) $display("FAIL start_state: got %h expected %h", st, exp_st);
        else pass_cnt++;
        // Score visible one cycle after the pulse, turn unchanged during CHECK.
        shooter_done = 1'b1; shooter_scored = 1'b1;
        tick();
        shooter_done = 1'b0; shooter_scored = 1'b0;
        exp_st = {4'd1, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (st !== exp_st) $display("FAIL check_cycle: got %h expected %h", st, exp_st);
        else pass_cnt++;
        tick();
        exp_st = {4'd1, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (st !== exp_st) $display("FAIL turn_to_keep: got %h expected %h", st, exp_st);
        else pass_cnt++;
        keep(0);
        for (int r = 2; r <= 3; r++) begin
            shoot(1);
            keep(0);
        end
        // 3:0 with CPU having 2 kicks left is already decided.
        exp_st = {4'd3, 4'd0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        total_cnt++;
        if (st !== exp_st) $display("FAIL early_win: got %h expected %h", st, exp_st);
        else pass_cnt++;
        shoot(1);
        keep(1);
        total_cnt++;
        if (st !== exp_st) $display("FAIL done_hold: got %h expected %h", st, exp_st);
        else pass_cnt++;
    endtask

    task automatic test_cpu_early();
        start();
        for (int r = 1; r <= 4; r++) begin
            shoot(r[0]);
            keep(1);
        end
        exp_st = {4'd2, 4'd4, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        total_cnt++;
        if (st !== exp_st) $display("FAIL cpu_early_win: got %h expected %h", st, exp_st);
        else pass_cnt++;
    endtask

    task automatic test_sudden_death();
        start();
        for (int r = 1; r <= 3; r++) begin shoot(1); keep(1); end
        for (int r = 4; r <= 5; r++) begin shoot(0); keep(0); end
        exp_st = {4'd3, 4'd3, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (st !== exp_st) $display("FAIL sd_enter: got %h expected %h", st, exp_st);
        else pass_cnt++;
        shoot(1);
        exp_st = {4'd4, 4'd3, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (st !== exp_st) $display("FAIL sd_half_round: got %h expected %h", st, exp_st);
        else pass_cnt++;
        keep(0);
        exp_st = {4'd4, 4'd3, 4'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        total_cnt++;
        if (st !== exp_st) $display("FAIL sd_win: got %h expected %h", st, exp_st);
        else pass_cnt++;
    endtask

    task automatic test_draw();
        start();
        for (int r = 1; r <= 14; r++) begin shoot(0); keep(0); end
        exp_st = {4'd0, 4'd0, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (st !== exp_st) $display("FAIL last_round: got %h expected %h", st, exp_st);
        else pass_cnt++;
        shoot(0);
        keep(0);
        exp_st = {4'd0, 4'd0, 4'd15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        total_cnt++;
        if (st !== exp_st) $display("FAIL max_round_draw: got %h expected %h", st, exp_st);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        start();
        keeper_done = 1'b1; keeper_conceded = 1'b1;
        tick();
        keeper_done = 1'b0; keeper_conceded = 1'b0;
        exp_st = {4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (st !== exp_st) $display("FAIL keeper_in_shoot: got %h expected %h", st, exp_st);
        else pass_cnt++;
        shoot(1);
        shooter_done = 1'b1; shooter_scored = 1'b1; keeper_done = 1'b1; keeper_conceded = 1'b1;
        tick();
        shooter_done = 1'b0; shooter_scored = 1'b0; keeper_done = 1'b0; keeper_conceded = 1'b0;
        tick();
        exp_st = {4'd1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (st !== exp_st) $display("FAIL both_in_keep: got %h expected %h", st, exp_st);
        else pass_cnt++;
        // A done held for three cycles must count as one kick.
        shooter_done = 1'b1; shooter_scored = 1'b1;
        tick(); tick(); tick();
        shooter_done = 1'b0; shooter_scored = 1'b0;
        exp_st = {4'd2, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (st !== exp_st) $display("FAIL held_done: got %h expected %h", st, exp_st);
        else pass_cnt++;
    endtask

    task automatic test_restart();
        start();
        shoot(1);
        match_start = 1'b1; keeper_done = 1'b1; keeper_conceded = 1'b1;
        tick();
        match_start = 1'b0; keeper_done = 1'b0; keeper_conceded = 1'b0;
        exp_st = {4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (st !== exp_st) $display("FAIL restart_clear: got %h expected %h", st, exp_st);
        else pass_cnt++;
        shoot(1);
        exp_st = {4'd1, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        total_cnt++;
        if (st !== exp_st) $display("FAIL restart_in_shoot: got %h expected %h", st, exp_st);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        start();
        for (int r = 1; r <= 5; r++) begin shoot(1); keep(1); end
        shoot(1);
        @(posedge clk);
        #3 rst = 1'b0;
        #2;
        total_cnt++;
        if (st !== 17'd0) $display("FAIL async_reset: got %h expected %h", st, 17'd0);
        else pass_cnt++;
        @(posedge clk); #1 rst = 1'b1;
        tick();
        total_cnt++;
        if (st !== 17'd0) $display("FAIL post_reset_idle: got %h expected %h", st, 17'd0);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b0;
        match_start = 1'b0; shooter_done = 1'b0; shooter_scored = 1'b0;
        keeper_done = 1'b0; keeper_conceded = 1'b0;
        test_reset();
        test_player_sweep();
        test_cpu_early();
        test_sudden_death();
        test_draw();
        test_back_to_back();
        test_restart();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
